// File: rtl/apb_arb_pkg.sv
// Shared types and sizing for the APB arbiter: FSM state, latched command, owner index width.
// Optional wait-state support is enabled with APB_ARB_PREADY_EN (see apb_arbiter.sv).
package apb_arb_pkg;

    localparam int ARB_NUM_REQ = 4;
    localparam int ARB_ADDR_W  = 32;
    localparam int ARB_DATA_W  = 32;
    localparam int OWNER_W     = $clog2(ARB_NUM_REQ);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    // Field widths follow the package constants; the top adapts them to its own parameters.
    typedef struct packed {
        logic                  write;
        logic [ARB_ADDR_W-1:0] addr;
        logic [ARB_DATA_W-1:0] wdata;
    } cmd_t;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/apb_arbiter_if.sv
// Bundle of requester-side and APB-side signals around the arbiter.
// pready exists only when APB_ARB_PREADY_EN is defined.
interface apb_arbiter_if
    import apb_arb_pkg::*;
#(
    parameter int NUM_REQ = ARB_NUM_REQ,
    parameter int ADDR_W  = ARB_ADDR_W,
    parameter int DATA_W  = ARB_DATA_W
) ();

    logic [NUM_REQ-1:0]             req_valid;
    logic [NUM_REQ-1:0]             req_write;
    logic [NUM_REQ-1:0][ADDR_W-1:0] req_addr;
    logic [NUM_REQ-1:0][DATA_W-1:0] req_wdata;
    logic [NUM_REQ-1:0]             req_grant;
    logic [NUM_REQ-1:0]             rsp_valid;
    logic [DATA_W-1:0]              rsp_rdata;

    logic [ADDR_W-1:0]              paddr;
    logic [DATA_W-1:0]              pwdata;
    logic                           pwrite;
    logic                           psel;
    logic                           penable;
    logic [DATA_W-1:0]              prdata;
`ifdef APB_ARB_PREADY_EN
    logic                           pready;
`endif

    // master: the arbiter itself; slave: requesters plus the APB completer
    modport master (
`ifdef APB_ARB_PREADY_EN
        input  pready,
`endif
        input  req_valid, req_write, req_addr, req_wdata, prdata,
        output req_grant, rsp_valid, rsp_rdata,
        output paddr, pwdata, pwrite, psel, penable
    );

    modport slave (
`ifdef APB_ARB_PREADY_EN
        output pready,
`endif
        output req_valid, req_write, req_addr, req_wdata, prdata,
        input  req_grant, rsp_valid, rsp_rdata,
        input  paddr, pwdata, pwrite, psel, penable
    );

endinterface

// File: rtl/apb_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or after ptr, wrapping.
module rr_arbiter
    import apb_arb_pkg::*;
#(
    parameter int NUM_REQ = ARB_NUM_REQ,
    parameter int IDX_W   = idx_width(ARB_NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   index,
    output logic               any
);

    logic [IDX_W-1:0] cand;

    always_comb begin
        grant = '0;
        index = '0;
        any   = 1'b0;
        cand  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = IDX_W'((int'(ptr) + i) % NUM_REQ);
            if (!any && req[cand]) begin
                any         = 1'b1;
                grant[cand] = 1'b1;
                index       = cand;
            end
        end
    end

endmodule

// File: rtl/apb_arbiter.sv
// Round-robin sharing of one APB master port among NUM_REQ requesters.
// Define APB_ARB_PREADY_EN to add pready and let ACCESS stretch with wait states.
module apb_arbiter
    import apb_arb_pkg::*;
#(
    parameter int NUM_REQ = ARB_NUM_REQ,
    parameter int ADDR_W  = ARB_ADDR_W,
    parameter int DATA_W  = ARB_DATA_W
) (
    input  logic          pclk,
    input  logic          presetn,
    apb_arbiter_if.master bus
);

    localparam int IDX_W = idx_width(NUM_REQ);

    state_t             state_reg, state_next;
    logic [IDX_W-1:0]   ptr_reg, ptr_next;
    logic [IDX_W-1:0]   owner_reg, owner_next;
    cmd_t               cmd_reg, cmd_next;
    logic [NUM_REQ-1:0] rsp_valid_reg, rsp_valid_next;
    logic [DATA_W-1:0]  rsp_rdata_reg, rsp_rdata_next;

    logic [NUM_REQ-1:0] owner_mask;
    logic [NUM_REQ-1:0] arb_req;
    logic [NUM_REQ-1:0] arb_grant;
    logic [IDX_W-1:0]   arb_index;
    logic               arb_any;
    logic               arb_en;
    logic               done;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_owner
            assign owner_mask[gi] = (owner_reg == IDX_W'(gi));
        end
    endgenerate

`ifdef APB_ARB_PREADY_EN
    assign done = (state_reg == ACCESS) && bus.pready;
`else
    assign done = (state_reg == ACCESS);
`endif

    // The finishing owner is kept out of the back-to-back pick in case it still holds valid.
    assign arb_en  = (state_reg == IDLE) || done;
    assign arb_req = (state_reg == ACCESS) ? (bus.req_valid & ~owner_mask) : bus.req_valid;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr (
        .req   (arb_req),
        .ptr   (ptr_reg),
        .grant (arb_grant),
        .index (arb_index),
        .any   (arb_any)
    );

    always_comb begin
        state_next     = state_reg;
        ptr_next       = ptr_reg;
        owner_next     = owner_reg;
        cmd_next       = cmd_reg;
        rsp_valid_next = '0;
        rsp_rdata_next = rsp_rdata_reg;

        case (state_reg)
            IDLE: begin
                if (arb_any) state_next = SETUP;
            end
            SETUP: begin
                state_next = ACCESS;
            end
            ACCESS: begin
                if (done) begin
                    rsp_valid_next = owner_mask;
                    rsp_rdata_next = cmd_reg.write ? '0 : bus.prdata;
                    state_next     = arb_any ? SETUP : IDLE;
                end
            end
            default: state_next = IDLE;
        endcase

        if (arb_en && arb_any) begin
            ptr_next       = (arb_index == IDX_W'(NUM_REQ - 1)) ? '0 : arb_index + 1'b1;
            owner_next     = arb_index;
            cmd_next.write = bus.req_write[arb_index];
            cmd_next.addr  = ARB_ADDR_W'(bus.req_addr[arb_index]);
            cmd_next.wdata = ARB_DATA_W'(bus.req_wdata[arb_index]);
        end
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_reg     <= IDLE;
            ptr_reg       <= '0;
            owner_reg     <= '0;
            cmd_reg       <= '0;
            rsp_valid_reg <= '0;
            rsp_rdata_reg <= '0;
        end else begin
            state_reg     <= state_next;
            ptr_reg       <= ptr_next;
            owner_reg     <= owner_next;
            cmd_reg       <= cmd_next;
            rsp_valid_reg <= rsp_valid_next;
            rsp_rdata_reg <= rsp_rdata_next;
        end
    end

    // Grant is combinational, so it is gated by reset explicitly.
    assign bus.req_grant = (arb_en && presetn) ? arb_grant : '0;
    assign bus.rsp_valid = rsp_valid_reg;
    assign bus.rsp_rdata = rsp_rdata_reg;
    assign bus.psel      = (state_reg != IDLE);
    assign bus.penable   = (state_reg == ACCESS);
    assign bus.pwrite    = cmd_reg.write;
    assign bus.paddr     = ADDR_W'(cmd_reg.addr);
    assign bus.pwdata    = DATA_W'(cmd_reg.wdata);

endmodule

// File: tb/tb_apb_arbiter.sv
// Directed-vector bench for apb_arbiter; wait-state vectors run when APB_ARB_PREADY_EN is defined.
module tb_apb_arbiter;

    localparam int N = 4;

    logic pclk    = 1'b0;
    logic presetn = 1'b0;
    int   vectors     = 0;
    int   miscompares = 0;

    apb_arbiter_if #(.NUM_REQ(N), .ADDR_W(32), .DATA_W(32)) bus ();

    apb_arbiter #(.NUM_REQ(N), .ADDR_W(32), .DATA_W(32)) u_dut (
        .pclk    (pclk),
        .presetn (presetn),
        .bus     (bus)
    );

    always #5 pclk = ~pclk;

    task automatic check_vec(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Inputs are driven 2 time units after the rising edge, outputs checked 1 unit later.
    task automatic tick();
        @(posedge pclk);
        #2;
    endtask

    initial begin
        bus.req_valid = '0;
        bus.req_write = '0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.prdata    = '0;
`ifdef APB_ARB_PREADY_EN
        bus.pready    = 1'b1;
`endif
        presetn = 1'b0;

        // ---- reset values, grant forced low even with a request pending
        tick();
        bus.req_valid = 4'b0010;
        #1;
        $display("txn reset: checking reset values");
        check_vec("rst_grant",   64'(bus.req_grant), 64'h0);
        check_vec("rst_psel",    64'(bus.psel),      64'h0);
        check_vec("rst_penable", 64'(bus.penable),   64'h0);
        check_vec("rst_pwrite",  64'(bus.pwrite),    64'h0);
        check_vec("rst_paddr",   64'(bus.paddr),     64'h0);
        check_vec("rst_pwdata",  64'(bus.pwdata),    64'h0);
        check_vec("rst_rspv",    64'(bus.rsp_valid), 64'h0);
        check_vec("rst_rdata",   64'(bus.rsp_rdata), 64'h0);
        bus.req_valid = '0;
        presetn = 1'b1;

        // ---- single read, requester 1
        tick();
        $display("txn read: req1 addr 0x10");
        bus.req_valid   = 4'b0010;
        bus.req_write   = 4'b0000;
        bus.req_addr[1] = 32'h10;
        #1;
        check_vec("rd_c0_grant", 64'(bus.req_grant), 64'h2);
        check_vec("rd_c0_psel",  64'(bus.psel),      64'h0);
        tick();
        bus.req_valid = '0;
        #1;
        check_vec("rd_c1_psel",    64'(bus.psel),      64'h1);
        check_vec("rd_c1_penable", 64'(bus.penable),   64'h0);
        check_vec("rd_c1_paddr",   64'(bus.paddr),     64'h10);
        check_vec("rd_c1_pwrite",  64'(bus.pwrite),    64'h0);
        check_vec("rd_c1_grant",   64'(bus.req_grant), 64'h0);
        tick();
        bus.prdata = 32'hDEADBEEF;
        #1;
        check_vec("rd_c2_psel",    64'(bus.psel),    64'h1);
        check_vec("rd_c2_penable", 64'(bus.penable), 64'h1);
        check_vec("rd_c2_paddr",   64'(bus.paddr),   64'h10);
        check_vec("rd_c2_rspv",    64'(bus.rsp_valid), 64'h0);
        tick();
        #1;
        check_vec("rd_c3_rspv",  64'(bus.rsp_valid), 64'h2);
        check_vec("rd_c3_rdata", 64'(bus.rsp_rdata), 64'hDEADBEEF);
        check_vec("rd_c3_psel",  64'(bus.psel),      64'h0);

        // ---- single write, requester 0 (pointer now at 2, wraps to 0)
        tick();
        $display("txn write: req0 addr 0x20 data 0x1234");
        bus.req_valid    = 4'b0001;
        bus.req_write    = 4'b0001;
        bus.req_addr[0]  = 32'h20;
        bus.req_wdata[0] = 32'h1234;
        #1;
        check_vec("wr_c0_grant", 64'(bus.req_grant), 64'h1);
        tick();
        bus.req_valid = '0;
        bus.req_write = '0;
        #1;
        check_vec("wr_c1_paddr",  64'(bus.paddr),  64'h20);
        check_vec("wr_c1_pwdata", 64'(bus.pwdata), 64'h1234);
        check_vec("wr_c1_pwrite", 64'(bus.pwrite), 64'h1);
        tick();
        bus.prdata = 32'h5555AAAA;
        #1;
        check_vec("wr_c2_penable", 64'(bus.penable), 64'h1);
        check_vec("wr_c2_pwrite",  64'(bus.pwrite),  64'h1);
        check_vec("wr_c2_pwdata",  64'(bus.pwdata),  64'h1234);
        tick();
        #1;
        check_vec("wr_c3_rspv",   64'(bus.rsp_valid), 64'h1);
        check_vec("wr_c3_rdata",  64'(bus.rsp_rdata), 64'h0);
        check_vec("wr_c3_psel",   64'(bus.psel),      64'h0);
        check_vec("wr_idle_addr", 64'(bus.paddr),     64'h20);
        check_vec("wr_idle_pwr",  64'(bus.pwrite),    64'h1);

        // ---- pointer at 1: requests 0 and 2 -> 2 first, then 0 back-to-back
        tick();
        $display("txn rr: req0+req2 with ptr=1");
        bus.req_valid   = 4'b0101;
        bus.req_addr[0] = 32'h30;
        bus.req_addr[2] = 32'h40;
        #1;
        check_vec("rr_c0_grant", 64'(bus.req_grant), 64'h4);
        tick();
        bus.req_valid = 4'b0001;
        #1;
        check_vec("rr_c1_grant", 64'(bus.req_grant), 64'h0);
        check_vec("rr_c1_paddr", 64'(bus.paddr),     64'h40);
        tick();
        bus.prdata = 32'h2222;
        #1;
        check_vec("rr_c2_grant",   64'(bus.req_grant), 64'h1);
        check_vec("rr_c2_penable", 64'(bus.penable),   64'h1);
        tick();
        bus.req_valid = '0;
        #1;
        check_vec("rr_c3_rspv",    64'(bus.rsp_valid), 64'h4);
        check_vec("rr_c3_rdata",   64'(bus.rsp_rdata), 64'h2222);
        check_vec("rr_c3_psel",    64'(bus.psel),      64'h1);
        check_vec("rr_c3_penable", 64'(bus.penable),   64'h0);
        check_vec("rr_c3_paddr",   64'(bus.paddr),     64'h30);
        tick();
        bus.prdata = 32'h3333;
        #1;
        tick();
        #1;
        check_vec("rr_c5_rspv",  64'(bus.rsp_valid), 64'h1);
        check_vec("rr_c5_rdata", 64'(bus.rsp_rdata), 64'h3333);
        check_vec("rr_c5_psel",  64'(bus.psel),      64'h0);

`ifdef APB_ARB_PREADY_EN
        // ---- three wait states on a read by requester 1, requester 2 waiting
        tick();
        $display("txn wait: req1 addr 0x50 with 3 wait states");
        bus.req_valid   = 4'b0010;
        bus.req_addr[1] = 32'h50;
        bus.req_addr[2] = 32'h60;
        #1;
        check_vec("ws_c0_grant", 64'(bus.req_grant), 64'h2);
        tick();
        bus.req_valid = '0;
        bus.pready    = 1'b0;
        #1;
        for (int c = 2; c <= 5; c++) begin
            tick();
            bus.req_valid = 4'b0100;
            bus.pready    = (c == 5);
            bus.prdata    = (c == 5) ? 32'h8888 : 32'h7777;
            #1;
            check_vec($sformatf("ws_c%0d_psel", c),    64'(bus.psel),      64'h1);
            check_vec($sformatf("ws_c%0d_penable", c), 64'(bus.penable),   64'h1);
            check_vec($sformatf("ws_c%0d_paddr", c),   64'(bus.paddr),     64'h50);
            check_vec($sformatf("ws_c%0d_rspv", c),    64'(bus.rsp_valid), 64'h0);
            check_vec($sformatf("ws_c%0d_grant", c),   64'(bus.req_grant), (c == 5) ? 64'h4 : 64'h0);
        end
        tick();
        bus.req_valid = '0;
        #1;
        check_vec("ws_c6_rspv",  64'(bus.rsp_valid), 64'h2);
        check_vec("ws_c6_rdata", 64'(bus.rsp_rdata), 64'h8888);
        check_vec("ws_c6_paddr", 64'(bus.paddr),     64'h60);
        tick();
        bus.prdata = 32'h9999;
        #1;
        tick();
        #1;
        check_vec("ws_c8_rspv",  64'(bus.rsp_valid), 64'h4);
        check_vec("ws_c8_rdata", 64'(bus.rsp_rdata), 64'h9999);
        check_vec("ws_c8_psel",  64'(bus.psel),      64'h0);
`endif

        // ---- reset asserted during ACCESS drops the transfer
        tick();
        $display("txn abort: req3 read, reset during ACCESS");
        bus.req_valid   = 4'b1000;
        bus.req_addr[3] = 32'h70;
        #1;
        check_vec("ab_c0_grant", 64'(bus.req_grant), 64'h8);
        tick();
        bus.req_valid = '0;
        tick();
        bus.prdata = 32'h4444;
        #1;
        check_vec("ab_c2_penable", 64'(bus.penable), 64'h1);
        presetn = 1'b0;
        #1;
        check_vec("ab_rst_psel",    64'(bus.psel),    64'h0);
        check_vec("ab_rst_penable", 64'(bus.penable), 64'h0);
        check_vec("ab_rst_paddr",   64'(bus.paddr),   64'h0);
        tick();
        #1;
        check_vec("ab_rst_rspv", 64'(bus.rsp_valid), 64'h0);
        presetn = 1'b1;

        // ---- all four requesters valid continuously from ptr=0
        tick();
        $display("txn burst: all four requesters valid");
        bus.req_write = '0;
        for (int i = 0; i < N; i++) bus.req_addr[i] = 32'h100 + 32'(4 * i);
        for (int c = 0; c < 10; c++) begin
            logic [63:0] exp_grant;
            logic [63:0] exp_rsp;
            if (c > 0) tick();
            bus.req_valid = 4'b1111;
            bus.prdata    = 32'hC0DE0000 + 32'(c);
            #1;
            exp_grant = (c % 2 == 0) ? 64'(1) << ((c / 2) % 4) : 64'h0;
            exp_rsp   = (c % 2 == 1 && c >= 3) ? 64'(1) << (((c - 3) / 2) % 4) : 64'h0;
            $display("txn burst cycle %0d: grant=%b rsp_valid=%b", c, bus.req_grant, bus.rsp_valid);
            check_vec($sformatf("bu_c%0d_grant", c),   64'(bus.req_grant), exp_grant);
            check_vec($sformatf("bu_c%0d_psel", c),    64'(bus.psel),      (c == 0) ? 64'h0 : 64'h1);
            check_vec($sformatf("bu_c%0d_penable", c), 64'(bus.penable),   (c % 2 == 0 && c > 0) ? 64'h1 : 64'h0);
            check_vec($sformatf("bu_c%0d_rspv", c),    64'(bus.rsp_valid), exp_rsp);
            if (c % 2 == 1) begin
                check_vec($sformatf("bu_c%0d_paddr", c), 64'(bus.paddr),
                          64'(32'h100 + 32'(4 * (((c - 1) / 2) % 4))));
                if (c >= 3)
                    check_vec($sformatf("bu_c%0d_rdata", c), 64'(bus.rsp_rdata),
                              64'(32'hC0DE0000 + 32'(c - 1)));
            end
        end
        tick();
        bus.req_valid = '0;
        bus.prdata    = 32'hC0DE000A;
        #1;
        check_vec("bu_c10_grant", 64'(bus.req_grant), 64'h0);
        tick();
        #1;
        check_vec("bu_c11_rspv",  64'(bus.rsp_valid), 64'h1);
        check_vec("bu_c11_rdata", 64'(bus.rsp_rdata), 64'hC0DE000A);
        check_vec("bu_c11_psel",  64'(bus.psel),      64'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/apb_arbiter.md
# apb_arbiter

Shares one APB master port among NUM_REQ local requesters and sequences each granted command through the APB SETUP/ACCESS phases. Sits between on-chip command sources (test sequencer, config engine, debug port) and the APB bus driven toward the slave side of the interface. Uses round-robin arbitration and returns read data to the winning requester.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- ADDR_W, 32, APB address width
- DATA_W, 32, APB data width
- pclk  in  1  APB clock; all logic on rising edge
- presetn  in  1  asynchronous, active-low reset
- req_valid  in  NUM_REQ  per-requester command pending; held stable until granted
- req_write  in  NUM_REQ  per-requester direction (1 = write)
- req_addr  in  NUM_REQ x ADDR_W  per-requester address
- req_wdata  in  NUM_REQ x DATA_W  per-requester write data
- req_grant  out  NUM_REQ  one-hot, one-cycle pulse: command captured this cycle
- rsp_valid  out  NUM_REQ  one-hot, one-cycle pulse: transfer complete
- rsp_rdata  out  DATA_W  read data for the rsp_valid owner; 0 for writes
- paddr, pwdata  out  ADDR_W, DATA_W  APB address / write data
- pwrite, psel, penable  out  1 each  APB control
- prdata  in  DATA_W  APB read data
- pready  in  1  slave ready (present only with APB_ARB_PREADY_EN)

## Operation
- FSM states IDLE, SETUP, ACCESS.
- IDLE: if any req_valid, pick winner, pulse req_grant[winner] (combinational), latch write/addr/wdata and owner index, go SETUP; else stay.
- SETUP: psel=1, penable=0; always go ACCESS next cycle.
- ACCESS: psel=1, penable=1; completes this cycle (or when pready=1 with macro). On completion: capture prdata (reads) or 0 (writes) into rsp_rdata, set rsp_valid[owner] next cycle; if any req_valid (owner excluded only if it has not dropped valid—owner must drop valid after grant) arbitrate again and go straight to SETUP (back-to-back, psel stays 1), else go IDLE with psel=0, penable=0.
- Round-robin: search starts at ptr; after grant ptr = winner+1 mod NUM_REQ. Reset ptr = 0.
- APB outputs paddr/pwdata/pwrite hold last value in IDLE.
- req_grant never asserted in SETUP or stalled ACCESS; new requests wait.
- Reset values: psel=0, penable=0, pwrite=0, paddr=0, pwdata=0, rsp_valid=0, rsp_rdata=0, req_grant=0 (forced while presetn low), state IDLE, ptr=0.
- Reset mid-transfer: outputs return to reset values asynchronously; in-flight command dropped, no rsp_valid.

## Timing
- Cycle 0: req_valid seen in IDLE, req_grant pulses. Cycle 1: SETUP. Cycle 2: ACCESS, prdata sampled at end. Cycle 3: rsp_valid + rsp_rdata. Latency 3 cycles, zero wait states.
- Back-to-back throughput: one transfer per 2 cycles.
- Each wait state (pready=0) adds one cycle to ACCESS and to latency.
- rsp_valid for transfer N may coincide with req_grant for transfer N+1 (different or same requester).

## Configuration
- APB_ARB_PREADY_EN defined: pready port exists; ACCESS holds (signals stable) until pready=1.
- Undefined: no pready port; ACCESS always lasts exactly one cycle.

## Structure
- apb_arb_pkg: state enum (IDLE, SETUP, ACCESS), command struct typedef (write, addr, wdata), owner index width constant $clog2(NUM_REQ).
- Sub-module rr_arbiter: req vector + ptr in, one-hot grant + index out, purely combinational; pointer register kept in apb_arbiter.

## Test plan
- Single read, req 1, addr 0x10, prdata 0xDEADBEEF -> grant[1] cycle 0, psel cycles 1-2, penable cycle 2, rsp_valid[1] cycle 3 with rdata 0xDEADBEEF.
- Single write req 0, addr 0x20, wdata 0x1234 -> paddr=0x20, pwdata=0x1234, pwrite=1 in SETUP/ACCESS; rsp_rdata=0.
- All 4 requesters valid continuously -> grant order 0,1,2,3,0; psel never drops; one transfer per 2 cycles.
- Requests 0 and 2 valid after ptr=1 -> 2 granted before 0.
- With APB_ARB_PREADY_EN, pready low 3 cycles -> ACCESS lasts 4 cycles, outputs stable, rsp_valid at cycle 6.
- presetn low during ACCESS -> psel/penable 0 immediately, no rsp_valid, after release ptr=0 and IDLE.
